// File: rtl/pal_pkg.sv
// Shared types for the custom palette loader: RGB24 entries tagged with their RAM index.
package pal_pkg;

  localparam int PAL_ENTRIES    = 64;
  localparam int PAL_CUSTOM_SEL = 14;

  typedef logic [23:0] rgb24_t;

  typedef struct packed {
    logic [5:0] idx;
    rgb24_t     rgb;
  } pal_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH
  } ld_state_t;

endpackage

// File: rtl/pal_entry_fifo.sv
// Small synchronous FIFO of assembled palette entries; a pop frees its slot for a same-cycle push.
module pal_entry_fifo
  import pal_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  pal_entry_t                    push_entry,
  input  logic                          pop,
  output pal_entry_t                    head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  pal_entry_t      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/palette_loader.sv
// Packs downloaded R,G,B bytes into palette entries and writes them to the custom palette RAM
// only while that palette is off screen or the beam is in blanking.
module palette_loader
  import pal_pkg::*;
#(
  parameter int NUM_ENTRIES = PAL_ENTRIES,
  parameter int INDEX_W     = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int CUSTOM_SEL  = PAL_CUSTOM_SEL
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dl_active,
  input  logic               dl_wr,
  input  logic [7:0]         dl_data,
  output logic               dl_wait,
  input  logic [3:0]         palette,
  input  logic               hblank,
  input  logic               vblank,
  output logic               load_color,
  output logic [INDEX_W-1:0] load_color_index,
  output logic [23:0]        load_color_data,
  output logic               pal_done,
  output logic               pal_valid,
  output logic               pal_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ld_state_t       state_q, state_d;
  logic            dl_active_d;
  logic            dl_rise;
  logic            start_ld, finish_ld, abort_partial;

  logic [1:0]      phase_p0;
  logic [6:0]      ent_cnt;
  logic [7:0]      r_byte_p0, g_byte_p0;
  logic            load_color_p1;

  logic            byte_acc, byte_take, byte_drop, entries_done;
  logic            push, pop, win;
  pal_entry_t      push_entry, head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign dl_rise      = dl_active & ~dl_active_d;
  assign entries_done = (ent_cnt == 7'(NUM_ENTRIES));
  assign win          = (palette != 4'(CUSTOM_SEL)) | hblank | vblank;
  assign pop          = win & ~fifo_empty;

  // Bytes past the last entry are swallowed silently; otherwise a full FIFO drops the byte.
  assign byte_acc   = (state_q == ST_LOAD) & dl_active & dl_wr;
  assign byte_take  = byte_acc & ~entries_done & (~fifo_full | pop);
  assign byte_drop  = byte_acc & ~entries_done & fifo_full & ~pop;
  assign push       = byte_take & (phase_p0 == 2'd2);
  assign push_entry = pal_entry_t'{idx: ent_cnt[5:0], rgb: {r_byte_p0, g_byte_p0, dl_data}};

  assign load_color = load_color_p1 & reset_n;

  pal_entry_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    start_ld      = 1'b0;
    finish_ld     = 1'b0;
    abort_partial = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dl_rise) begin
          state_d  = ST_LOAD;
          start_ld = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!dl_active) begin
          state_d       = ST_FLUSH;
          abort_partial = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (dl_rise) begin
          state_d  = ST_LOAD;
          start_ld = 1'b1;
        end else if (fifo_empty && !load_color_p1) begin
          state_d   = ST_IDLE;
          finish_ld = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // p0: byte capture into the R/G holding registers
  always_ff @(posedge clk) begin
    if (byte_take && phase_p0 == 2'd0) r_byte_p0 <= dl_data;
    if (byte_take && phase_p0 == 2'd1) g_byte_p0 <= dl_data;
  end

  // p1: control, status and the registered RAM write port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      dl_active_d      <= 1'b0;
      phase_p0         <= 2'd0;
      ent_cnt          <= '0;
      dl_wait          <= 1'b0;
      load_color_p1    <= 1'b0;
      load_color_index <= '0;
      load_color_data  <= '0;
      pal_done         <= 1'b0;
      pal_valid        <= 1'b0;
      pal_overflow     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_active_d <= dl_active;
      pal_done    <= finish_ld;
      if (start_ld) begin
        phase_p0     <= 2'd0;
        ent_cnt      <= '0;
        pal_valid    <= 1'b0;
        pal_overflow <= 1'b0;
      end else begin
        if (abort_partial)  phase_p0 <= 2'd0;
        else if (byte_take) phase_p0 <= (phase_p0 == 2'd2) ? 2'd0 : phase_p0 + 2'd1;
        if (push)      ent_cnt      <= ent_cnt + 7'd1;
        if (byte_drop) pal_overflow <= 1'b1;
        if (finish_ld) pal_valid    <= entries_done;
      end
      // Raised one entry early so a back-to-back byte cannot land on a full FIFO.
      dl_wait <= ~entries_done &
                 (fifo_full | (fifo_count == CW'(FIFO_DEPTH - 1) && phase_p0 == 2'd2));
      load_color_p1 <= pop;
      if (pop) begin
        load_color_index <= head.idx;
        load_color_data  <= head.rgb;
      end
    end
  end

endmodule
